// File: rtl/bsg_wormhole_packet_arbiter_pkg.sv
// bsg_wormhole_packet_arbiter_pkg: shared arbiter state encoding
package bsg_wormhole_packet_arbiter_pkg;
  typedef enum logic {e_idle, e_lock} state_e;
endpackage

// File: rtl/bsg_wormhole_rr_pick.sv
// bsg_wormhole_rr_pick: first valid requester at or after rr_ptr, wrapping
module bsg_wormhole_rr_pick
  import bsg_wormhole_packet_arbiter_pkg::*;
#(
  parameter int els_p = 4,
  parameter int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic [lg_els_lp-1:0] rr_ptr_i,
  input  logic [els_p-1:0]     v_i,
  output logic [lg_els_lp-1:0] sel_o,
  output logic                 any_v_o
);
  logic [lg_els_lp-1:0] idx;
  // scan farthest-first so the candidate closest to rr_ptr wins
  always_comb begin
    sel_o = '0;
    idx = '0;
    for (int k = els_p - 1; k >= 0; k--) begin
      idx = lg_els_lp'((int'(rr_ptr_i) + k) % els_p);
      if (v_i[idx]) sel_o = idx;
    end
  end
  assign any_v_o = |v_i;
endmodule

// File: rtl/bsg_wormhole_packet_arbiter.sv
// bsg_wormhole_packet_arbiter: packet-atomic round-robin share of one wormhole link
module bsg_wormhole_packet_arbiter
  import bsg_wormhole_packet_arbiter_pkg::*;
#(
  parameter int els_p = 4,
  parameter int flit_width_p = 32,
  parameter int cord_width_p = 5,
  parameter int len_width_p = 4,
  parameter int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [els_p-1:0]              v_i,
  input  logic [els_p*flit_width_p-1:0] data_i,
  output logic [els_p-1:0]              ready_and_o,
  output logic                          v_o,
  output logic [flit_width_p-1:0]       data_o,
  input  logic                          ready_and_i,
  output logic                          lock_o,
  output logic [lg_els_lp-1:0]          lock_id_o,
  output logic                          pkt_done_o
);
  typedef struct packed {
    logic [flit_width_p-cord_width_p-len_width_p-1:0] payload;
    logic [len_width_p-1:0]                           len;
    logic [cord_width_p-1:0]                          cord;
  } hdr_s;
  state_e               state;
  logic [len_width_p-1:0] cnt;
  logic [lg_els_lp-1:0] rr_ptr, lock_id, pick_sel, sel, nxt;
  logic                 any_v, hs, done;
  hdr_s                 flit;
  bsg_wormhole_rr_pick #(.els_p(els_p), .lg_els_lp(lg_els_lp)) pick (
    .rr_ptr_i(rr_ptr),
    .v_i(v_i),
    .sel_o(pick_sel),
    .any_v_o(any_v)
  );
  assign sel = (state == e_lock) ? lock_id : pick_sel;
  assign flit = hdr_s'(data_i[int'(sel)*flit_width_p +: flit_width_p]);
  assign data_o = flit;
  assign v_o = reset_n_i & ((state == e_lock) ? v_i[lock_id] : any_v);
  assign hs = v_o & ready_and_i;
  assign done = hs & ((state == e_idle) ? (flit.len == '0) : (cnt == len_width_p'(1)));
  assign pkt_done_o = done;
  assign ready_and_o = reset_n_i ? (els_p'(ready_and_i) << sel) : '0;
  assign nxt = (int'(sel) == els_p - 1) ? '0 : sel + 1'b1;
  assign lock_o = (state == e_lock);
  assign lock_id_o = lock_id;
  // header opens a packet, body handshakes count down, completion advances rr_ptr
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state <= e_idle;
      cnt <= '0;
      rr_ptr <= '0;
      lock_id <= '0;
    end else if (hs) begin
      if (state == e_idle) begin
        if (flit.len == '0) rr_ptr <= nxt;
        else begin
          state <= e_lock;
          cnt <= flit.len;
          lock_id <= sel;
        end
      end else begin
        cnt <= cnt - 1'b1;
        if (cnt == len_width_p'(1)) begin
          state <= e_idle;
          rr_ptr <= nxt;
        end
      end
    end
endmodule
